// File: rtl/rescap_meas_ctrl.sv
// -----------------------------------------------------------------------------
// rescap_meas_ctrl
//
// Sequencer for an RC time-constant measurement. Discharges the capacitor,
// charges it through the series resistor and counts clk cycles until the
// (synchronised) comparator reports that vout has crossed its threshold.
// The count is returned over a valid/ready result interface.
//
// Optional build macro: RESCAP_MEAS_CTRL_AVG_EN
//   Defined   : one start runs 2**AVG_LOG2 back-to-back measurements and
//               reports the truncated average of their counts.
//   Undefined : one measurement per start, no accumulator.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle measurement request (honoured in IDLE only)
//   abort         synchronous cancel (honoured in GAP_D/DISCH/GAP_C/CHARGE)
//   cmp_in        asynchronous comparator output, 1 = vout above threshold
//   chg_en        closes vdd-to-resistor switch (registered)
//   dis_en        closes vout-to-vss discharge switch (registered)
//   busy          measurement in progress or result pending
//   result        measured charge cycles
//   result_valid  result available
//   result_ready  consumer accepts result
//   timeout       qualifies result: threshold not reached, or cap not discharged
//
// Result handshake: result/timeout are held stable while result_valid=1 and
// the transfer happens on a rising clk edge with result_valid && result_ready.
// result_valid drops on the following cycle.
// -----------------------------------------------------------------------------
module rescap_meas_ctrl #(
    parameter int CNT_W          = 16,
    parameter int DISCH_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int AVG_LOG2       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             chg_en,
    output logic             dis_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP_D  = 3'd1,
        S_DISCH  = 3'd2,
        S_GAP_C  = 3'd3,
        S_CHARGE = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DISCH_LAST = CNT_W'(DISCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           next_state;
    logic             cmp_meta;
    logic             cmp_s;
    logic [CNT_W-1:0] cnt;
    logic             last_run;
    logic [CNT_W-1:0] run_result;

    logic             chg_en_d;
    logic             dis_en_d;
    logic             busy_d;
    logic             valid_d;
    logic [CNT_W-1:0] result_d;
    logic             timeout_d;

    // Two-flop synchroniser for the asynchronous comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    // Shared phase counter: counts DISCH cycles, then CHARGE cycles.
    // Cleared in each gap so both phases start from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                S_DISCH, S_CHARGE: cnt <= cnt + CNT_W'(1);
                default:           cnt <= '0;
            endcase
        end
    end

`ifdef RESCAP_MEAS_CTRL_AVG_EN
    localparam int                ACC_W    = CNT_W + AVG_LOG2;
    localparam int                RUN_W    = AVG_LOG2 + 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [RUN_W-1:0] run_idx;

    assign acc_sum    = acc + ACC_W'(cnt);
    assign last_run   = (run_idx == RUN_LAST);
    assign run_result = CNT_W'(acc_sum >> AVG_LOG2);

    // Batch accumulator: cleared on start, updated when a non-final run
    // crosses and the sequencer loops back for the next run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            run_idx <= '0;
        end else if (state == S_IDLE && start) begin
            acc     <= '0;
            run_idx <= '0;
        end else if (state == S_CHARGE && next_state == S_GAP_D) begin
            acc     <= acc_sum;
            run_idx <= run_idx + RUN_W'(1);
        end
    end
`else
    // Single run per start: every run is the final one.
    logic unused_avg_cfg;
    assign unused_avg_cfg = (AVG_LOG2 != 0);
    assign last_run       = 1'b1;
    assign run_result     = cnt;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic. abort outranks phase completion.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_GAP_D;
            end
            S_GAP_D: begin
                next_state = abort ? S_IDLE : S_DISCH;
            end
            S_DISCH: begin
                if (abort)                   next_state = S_IDLE;
                else if (cnt == DISCH_LAST)  next_state = cmp_s ? S_REPORT : S_GAP_C;
            end
            S_GAP_C: begin
                next_state = abort ? S_IDLE : S_CHARGE;
            end
            S_CHARGE: begin
                if (abort)               next_state = S_IDLE;
                else if (cmp_s)          next_state = last_run ? S_REPORT : S_GAP_D;
                else if (cnt == TO_LAST) next_state = S_REPORT;
            end
            S_REPORT: begin
                if (result_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    // A switch may only close if the other one is open in the current cycle,
    // which forces a both-open cycle on every hand-over (including abort from
    // CHARGE to IDLE and the CHARGE to REPORT transition).
    always_comb begin
        chg_en_d  = (next_state == S_CHARGE) && !dis_en;
        dis_en_d  = (next_state == S_IDLE || next_state == S_DISCH ||
                     next_state == S_REPORT) && !chg_en;
        busy_d    = (next_state != S_IDLE);
        valid_d   = (next_state == S_REPORT);
        result_d  = result;
        timeout_d = timeout;
        case (state)
            S_IDLE: begin
                if (start) begin
                    result_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            S_DISCH: begin
                // Capacitor still above threshold after discharge.
                if (next_state == S_REPORT) begin
                    result_d  = '1;
                    timeout_d = 1'b1;
                end
            end
            S_CHARGE: begin
                if (next_state == S_REPORT) begin
                    if (cmp_s) begin
                        result_d = run_result;
                    end else begin
                        result_d  = TO_VAL;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_en       <= 1'b0;
            dis_en       <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            timeout      <= 1'b0;
        end else begin
            chg_en       <= chg_en_d;
            dis_en       <= dis_en_d;
            busy         <= busy_d;
            result_valid <= valid_d;
            result       <= result_d;
            timeout      <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rescap_meas_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for rescap_meas_ctrl.
// DUT built with DISCH_CYCLES=64, TIMEOUT_CYCLES=100, CNT_W=16, AVG_LOG2=2.
// Crossing delay d (cycles from chg_en rising to cmp_in rising) gives an
// expected result of d+2 because of the 2-flop synchroniser.
// -----------------------------------------------------------------------------
module tb_rescap_meas_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             cmp_in;
    logic             chg_en;
    logic             dis_en;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    // monitor state
    int   overlap_cnt = 0;
    int   bbm_cnt     = 0;
    int   chg_rises   = 0;
    logic chg_ever    = 1'b0;
    logic valid_ever  = 1'b0;
    logic prev_chg    = 1'b0;
    logic prev_dis    = 1'b1;
    logic prev_ok     = 1'b0;

    rescap_meas_ctrl #(
        .CNT_W(CNT_W),
        .DISCH_CYCLES(64),
        .TIMEOUT_CYCLES(100),
        .AVG_LOG2(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .cmp_in(cmp_in),
        .chg_en(chg_en),
        .dis_en(dis_en),
        .busy(busy),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .timeout(timeout)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // switch monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && prev_ok) begin
            if (chg_en && dis_en) overlap_cnt++;
            if ((chg_en && prev_dis) || (dis_en && prev_chg)) bbm_cnt++;
            if (chg_en && !prev_chg) chg_rises++;
        end
        if (chg_en) chg_ever = 1'b1;
        if (result_valid) valid_ever = 1'b1;
        prev_chg = chg_en;
        prev_dis = dis_en;
        prev_ok  = rst_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_chg(input string tag);
        int n = 0;
        @(negedge clk);
        while (!chg_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, chg_en}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!result_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, result_valid}, 32'd1);
    endtask

    // One charge phase: cmp_in rises d cycles after chg_en, then is
    // released once the charge switch opens again.
    task automatic do_run(input string tag, input int d);
        int n = 0;
        wait_chg(tag);
        repeat (d) @(posedge clk);
        #1 cmp_in = 1'b1;
        @(negedge clk);
        while (chg_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_chg_fall"}, {31'd0, chg_en}, 32'd0);
        cmp_in = 1'b0;
    endtask

    task automatic handshake(input string tag);
        @(posedge clk); #1 result_ready = 1'b1;
        @(posedge clk); #1 result_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_low"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_busy_low"},  {31'd0, busy},         32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        cmp_in       = 1'b0;
        result_ready = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_chg_en",  {31'd0, chg_en},       32'd0);
        check("rst_dis_en",  {31'd0, dis_en},       32'd1);
        check("rst_busy",    {31'd0, busy},         32'd0);
        check("rst_result",  {16'd0, result},       32'd0);
        check("rst_valid",   {31'd0, result_valid}, 32'd0);
        check("rst_timeout", {31'd0, timeout},      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_dis_en", {31'd0, dis_en}, 32'd1);
        check("idle_busy",   {31'd0, busy},   32'd0);

`ifdef RESCAP_MEAS_CTRL_AVG_EN
        // ---------------- averaging: 9,10,9,11 -> 39>>2 = 9 ----------------
        chg_rises = 0;
        pulse_start();
        do_run("avg_run0", 7);
        do_run("avg_run1", 8);
        do_run("avg_run2", 7);
        do_run("avg_run3", 9);
        wait_valid("avg_valid");
        check("avg_result",  {16'd0, result}, 32'd9);
        check("avg_timeout", {31'd0, timeout}, 32'd0);
        check("avg_runs",    chg_rises, 32'd4);
        handshake("avg_hs");

        // ---------------- averaging: timeout on run 2 ----------------
        chg_rises = 0;
        pulse_start();
        do_run("avgto_run0", 7);
        wait_valid("avgto_valid");
        check("avgto_result",  {16'd0, result}, 32'd100);
        check("avgto_timeout", {31'd0, timeout}, 32'd1);
        check("avgto_runs",    chg_rises, 32'd2);
        handshake("avgto_hs");
`else
        // ---------------- nominal: delay 7 -> result 9 ----------------
        pulse_start();
        do_run("nom", 7);
        wait_valid("nom_valid");
        check("nom_result",  {16'd0, result},  32'd9);
        check("nom_timeout", {31'd0, timeout}, 32'd0);
        check("nom_busy",    {31'd0, busy},    32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nom_hold_valid",  {31'd0, result_valid}, 32'd1);
            check("nom_hold_result", {16'd0, result},       32'd9);
        end
        check("nom_report_dis", {31'd0, dis_en}, 32'd1);
        handshake("nom_hs");
        check("nom_kept_result", {16'd0, result}, 32'd9);

        // ---------------- timeout: cmp held 0 ----------------
        pulse_start();
        wait_valid("to_valid");
        check("to_result",  {16'd0, result},  32'd100);
        check("to_timeout", {31'd0, timeout}, 32'd1);
        check("to_chg_off", {31'd0, chg_en},  32'd0);
        handshake("to_hs");

        // ---------------- stuck high: cmp held 1 ----------------
        cmp_in   = 1'b1;
        chg_ever = 1'b0;
        pulse_start();
        wait_valid("stuck_valid");
        check("stuck_result",  {16'd0, result},    32'h0000FFFF);
        check("stuck_timeout", {31'd0, timeout},   32'd1);
        check("stuck_no_chg",  {31'd0, chg_ever},  32'd0);
        handshake("stuck_hs");
        cmp_in = 1'b0;
        repeat (4) @(negedge clk);

        // ---------------- abort in third CHARGE cycle ----------------
        valid_ever = 1'b0;
        pulse_start();
        wait_chg("abort_chg");
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_chg_drop", {31'd0, chg_en}, 32'd0);
        check("abort_gap_dis",  {31'd0, dis_en}, 32'd0);
        check("abort_busy",     {31'd0, busy},   32'd0);
        @(negedge clk);
        check("abort_dis_rise", {31'd0, dis_en}, 32'd1);
        repeat (5) @(negedge clk);
        check("abort_no_valid", {31'd0, valid_ever}, 32'd0);

        // ---------------- following start runs normally: delay 20 -> 22 ----
        pulse_start();
        do_run("post", 20);
        wait_valid("post_valid");
        check("post_result",  {16'd0, result},  32'd22);
        check("post_timeout", {31'd0, timeout}, 32'd0);
        // start in REPORT must be ignored
        pulse_start();
        @(negedge clk);
        check("rep_start_valid",  {31'd0, result_valid}, 32'd1);
        check("rep_start_result", {16'd0, result},       32'd22);
        handshake("post_hs");
        repeat (3) @(negedge clk);
        check("rep_start_idle", {31'd0, busy}, 32'd0);
`endif

        // ---------------- reset mid-charge ----------------
        pulse_start();
        wait_chg("rstmid_chg");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_chg_en",  {31'd0, chg_en},       32'd0);
        check("rstmid_dis_en",  {31'd0, dis_en},       32'd1);
        check("rstmid_busy",    {31'd0, busy},         32'd0);
        check("rstmid_valid",   {31'd0, result_valid}, 32'd0);
        check("rstmid_result",  {16'd0, result},       32'd0);
        check("rstmid_timeout", {31'd0, timeout},      32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- switch safety over the whole run ----------------
        check("never_both_on",     overlap_cnt, 32'd0);
        check("break_before_make", bbm_cnt,     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
